// File: rtl/dreg_pipe_pkg.sv
// Shared defaults for the dreg_pipe elastic register pipeline.
package dreg_pipe_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/dreg_stage.sv
// One pipeline slot: a valid bit plus a data word, loaded from the upstream slot.
module dreg_stage
    import dreg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             load,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    // Valid bit: follows the upstream slot when loading, dropped on flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
        end else begin
            valid <= valid;
        end
    end

    // Data word: only a real word overwrites it, so bubbles keep the last value.
    always_ff @(posedge clk) begin
        if (clr) begin
            data <= {WIDTH{1'b0}};
        end else if (load && valid_in) begin
            data <= d_in;
        end else begin
            data <= data;
        end
    end
endmodule

// File: rtl/dreg_pipe.sv
// Elastic register pipeline of DEPTH slots with valid/ready handshakes,
// bubble compaction, flush and an occupancy counter.
module dreg_pipe
    import dreg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] take_s;
    logic [DEPTH-1:0] vin_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [WIDTH-1:0] din_s  [DEPTH];
    logic             carry_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [OCC_W-1:0] occ_next_s;

    // A slot can take new content when it is empty or its own word moves on;
    // walking back from the output turns that into the advance chain.
    always_comb begin
        take_s  = {DEPTH{1'b0}};
        carry_s = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry_s   = !valid_s[k] || carry_s;
            take_s[k] = carry_s;
        end
    end

    assign in_ready  = take_s[0] && !flush && !clr;
    assign out_valid = valid_s[DEPTH-1];
    assign q         = data_s[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign vin_s[k] = in_valid && in_ready;
            assign din_s[k] = d;
        end else begin : g_body
            assign vin_s[k] = valid_s[k-1];
            assign din_s[k] = data_s[k-1];
        end

        dreg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .clr      (clr),
            .clear    (flush),
            .load     (take_s[k]),
            .valid_in (vin_s[k]),
            .d_in     (din_s[k]),
            .valid    (valid_s[k]),
            .data     (data_s[k])
        );
    end

    // Occupancy only changes on an unmatched transfer in or out.
    always_comb begin
        in_xfer_s  = in_valid && in_ready;
        out_xfer_s = out_valid && out_ready;
        occ_next_s = occupancy;
        if (in_xfer_s && !out_xfer_s) begin
            occ_next_s = occupancy + OCC_W'(1);
        end else if (out_xfer_s && !in_xfer_s) begin
            occ_next_s = occupancy - OCC_W'(1);
        end else begin
            occ_next_s = occupancy;
        end
    end

    // Occupancy register, emptied by reset or flush.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            occupancy <= {OCC_W{1'b0}};
        end else begin
            occupancy <= occ_next_s;
        end
    end
endmodule

// File: tb/tb_dreg_pipe.sv
// Self-checking bench for dreg_pipe: directed scenarios on DEPTH=4 and DEPTH=1
// instances plus randomized traffic against a queue-based timing model.
module tb_dreg_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, flush, in_valid, out_ready;
    logic [7:0] d;
    logic       rdy4, ov4, rdy1, ov1;
    logic [7:0] q4, q1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    dreg_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .d(d), .out_valid(ov4), .out_ready(out_ready), .q(q4), .occupancy(occ4));

    dreg_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .d(d), .out_valid(ov1), .out_ready(out_ready), .q(q1), .occupancy(occ1));

    logic       sel;
    logic       o_ready, o_valid;
    logic [7:0] o_q;
    logic [2:0] o_occ;
    assign o_ready = sel ? rdy1 : rdy4;
    assign o_valid = sel ? ov1  : ov4;
    assign o_q     = sel ? q1   : q4;
    assign o_occ   = sel ? {2'b00, occ1} : occ4;

    int checks = 0;
    int errors = 0;

    // Reference model: words in acceptance order with their acceptance cycle.
    // A word reaches the output DEPTH cycles after acceptance, or one cycle
    // after its predecessor leaves, whichever is later.
    logic [7:0] mq[$];
    int         acc[$];
    int         cyc = 0;
    int         last_out = -100;
    int         depth = 4;
    logic       e_ready, e_valid;
    logic [7:0] e_q;
    logic [2:0] e_occ;

    task automatic model_eval();
        int vis;
        e_ready = !clr && !flush && !((mq.size() == depth) && !out_ready);
        e_valid = 1'b0;
        e_q     = 8'h00;
        if (mq.size() > 0) begin
            vis = acc[0] + depth;
            if (last_out + 1 > vis) vis = last_out + 1;
            e_valid = (cyc >= vis);
            e_q     = mq[0];
        end
        e_occ = 3'(mq.size());
    endtask

    task automatic model_step();
        if (clr) begin
            mq.delete();
            acc.delete();
        end else begin
            if (e_valid && out_ready) begin
                void'(mq.pop_front());
                void'(acc.pop_front());
                last_out = cyc;
            end
            if (flush) begin
                mq.delete();
                acc.delete();
            end else if (in_valid && e_ready) begin
                mq.push_back(d);
                acc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic c, input logic f, input logic iv,
                         input logic [7:0] dd, input logic ordy);
        clr = c; flush = f; in_valid = iv; d = dd; out_ready = ordy;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
            else       drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            sample();
            checks++;
            if (o_ready !== (c == 2)) begin
                errors++; $display("FAIL reset_in_ready: got %b want %b at step %0d", o_ready, (c == 2), c);
            end
            if (c >= 1) begin
                checks++;
                if (o_q !== 8'h00 || o_valid !== 1'b0 || o_occ !== 3'd0) begin
                    errors++;
                    $display("FAIL reset_state: q=%h valid=%b occ=%0d want 00/0/0", o_q, o_valid, o_occ);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        drive(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
        sample();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL latency_accept: in_ready %b want 1", o_ready);
        end
        tick();
        for (int c = 1; c <= 6; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            sample();
            checks++;
            if (o_valid !== (c == 4)) begin
                errors++; $display("FAIL latency_valid: out_valid %b want %b at cycle %0d", o_valid, (c == 4), c);
            end
            if (c == 4) begin
                checks++;
                if (o_q !== 8'hA5) begin
                    errors++; $display("FAIL latency_q: q %h want a5", o_q);
                end
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int seen = 0;
        int first = -1;
        for (int k = 0; k < 26; k++) begin
            if (k < 16) drive(1'b0, 1'b0, 1'b1, 8'(k + 1), 1'b1);
            else        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            sample();
            if (seen > 0 && seen < 16) begin
                checks++;
                if (o_valid !== 1'b1) begin
                    errors++; $display("FAIL stream_gap: out_valid %b want 1 at step %0d", o_valid, k);
                end
            end
            if (o_valid === 1'b1) begin
                if (first < 0) first = k;
                checks++;
                if (o_q !== 8'(seen + 1)) begin
                    errors++; $display("FAIL stream_q: q %h want %h", o_q, 8'(seen + 1));
                end
                seen++;
            end
            tick();
        end
        checks++;
        if (first != 4) begin
            errors++; $display("FAIL stream_latency: first output at step %0d want 4", first);
        end
        checks++;
        if (seen != 16) begin
            errors++; $display("FAIL stream_count: %0d words out want 16", seen);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h11 + k), 1'b0);
            sample();
            checks++;
            if (o_ready !== 1'b1) begin
                errors++; $display("FAIL stall_fill_ready: in_ready %b want 1 at word %0d", o_ready, k);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 8'h15, 1'b0);
        sample();
        checks++;
        if (o_occ !== 3'd4 || o_ready !== 1'b0) begin
            errors++; $display("FAIL stall_full: occ %0d in_ready %b want 4/0", o_occ, o_ready);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'h15, 1'b1);
        sample();
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'h11 || o_ready !== 1'b1) begin
            errors++; $display("FAIL stall_swap: valid %b q %h in_ready %b want 1/11/1", o_valid, o_q, o_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            sample();
            checks++;
            if (o_valid !== 1'b1 || o_q !== 8'(8'h12 + i)) begin
                errors++; $display("FAIL stall_drain: valid %b q %h want 1/%h", o_valid, o_q, 8'(8'h12 + i));
            end
            if (i == 0) begin
                checks++;
                if (o_occ !== 3'd4) begin
                    errors++; $display("FAIL stall_occ: occ %0d want 4", o_occ);
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        sample();
        checks++;
        if (o_valid !== 1'b0 || o_occ !== 3'd0) begin
            errors++; $display("FAIL stall_empty: valid %b occ %0d want 0/0", o_valid, o_occ);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h31 + k), 1'b0);
            sample();
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        sample();
        checks++;
        if (o_occ !== 3'd3 || o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre: occ %0d in_ready %b want 3/0", o_occ, o_ready);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            sample();
            checks++;
            if (o_valid !== 1'b0 || (i == 0 && o_occ !== 3'd0)) begin
                errors++; $display("FAIL flush_post: valid %b occ %0d q %h want 0/0 at step %0d", o_valid, o_occ, o_q, i);
            end
            tick();
        end
    endtask

    task automatic test_depth1();
        logic [7:0] sb[$];
        logic [7:0] w;
        sel = 1'b1;
        depth = 1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), (i % 2 == 0));
            sample();
            checks++;
            if (o_ready !== (!o_valid || out_ready)) begin
                errors++; $display("FAIL d1_in_ready: in_ready %b want %b", o_ready, (!o_valid || out_ready));
            end
            if (o_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL d1_extra: q %h emitted with nothing pending", o_q);
                end else begin
                    w = sb.pop_front();
                    if (o_q !== w) begin
                        errors++; $display("FAIL d1_order: q %h want %h", o_q, w);
                    end
                end
            end
            if (o_ready) sb.push_back(d);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checks++;
        if (o_occ !== 3'(sb.size())) begin
            errors++; $display("FAIL d1_occ: occ %0d want %0d", o_occ, sb.size());
        end
        tick();
    endtask

    task automatic test_random(input logic s);
        sel = s;
        depth = s ? 1 : 4;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            sample();
            tick();
        end
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(49) == 0), ($urandom_range(19) == 0),
                  ($urandom_range(9) < 6), 8'($urandom), ($urandom_range(9) < 6));
            sample();
            checks++;
            if (o_ready !== e_ready) begin
                errors++; $display("FAIL rand_in_ready: got %b want %b (depth %0d step %0d)", o_ready, e_ready, depth, i);
            end
            checks++;
            if (o_valid !== e_valid) begin
                errors++; $display("FAIL rand_out_valid: got %b want %b (depth %0d step %0d)", o_valid, e_valid, depth, i);
            end
            checks++;
            if (o_occ !== e_occ) begin
                errors++; $display("FAIL rand_occupancy: got %0d want %0d (depth %0d step %0d)", o_occ, e_occ, depth, i);
            end
            if (e_valid) begin
                checks++;
                if (o_q !== e_q) begin
                    errors++; $display("FAIL rand_q: got %h want %h (depth %0d step %0d)", o_q, e_q, depth, i);
                end
            end
            tick();
        end
    endtask

    initial begin
        sel = 1'b0;
        depth = 4;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_flush();
        test_depth1();
        test_random(1'b0);
        test_random(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dreg_pipe.md
DREG_PIPE -- requirements
Module: dreg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  synchronous discard of all in-flight data.
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  pipe accepts d this cycle.
REQ-008 d  input  WIDTH  upstream data.
REQ-009 out_valid  output  1  q holds valid data.
REQ-010 out_ready  input  1  downstream accepts q this cycle.
REQ-011 q  output  WIDTH  data of last stage.
REQ-012 occupancy  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold one data word and one valid bit; stage 0 is the input stage, stage DEPTH-1 drives q and out_valid.
REQ-014 Stage DEPTH-1 SHALL advance when out_ready=1; stage k<DEPTH-1 SHALL advance when stage k+1 is empty or stage k+1 advances in the same cycle.
REQ-015 in_ready SHALL be combinational: (stage 0 empty or stage 0 advances) and flush=0 and clr=0.
REQ-016 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out with out_valid=1 and out_ready=1.
REQ-017 A word accepted into an empty pipe with out_ready held 1 SHALL appear on q with out_valid=1 exactly DEPTH cycles after acceptance.
REQ-018 With out_ready=1 continuously and in_valid=1 continuously, throughput SHALL be one word per cycle with no bubbles.
REQ-019 With out_ready=0, words SHALL compact toward stage DEPTH-1 (bubbles collapse) until all DEPTH stages are valid; in_ready SHALL then be 0.
REQ-020 Full pipe with out_ready=1 and in_valid=1 in the same cycle SHALL accept and emit simultaneously; occupancy unchanged.
REQ-021 Words SHALL leave in acceptance order; no word duplicated or dropped except by flush or clr.
REQ-022 occupancy SHALL be registered and equal the number of set valid bits after each edge.
REQ-023 q SHALL hold its value while out_valid=1 and out_ready=0.
REQ-024 Data registers of empty stages SHALL retain their last value (never X after reset); q is don't-care-to-consumer when out_valid=0.
REQ-025 flush=1 SHALL clear all valid bits and occupancy on the next edge; any word presented that cycle SHALL NOT be accepted; any out transfer that cycle SHALL still complete.
REQ-026 DEPTH=1 SHALL behave as a single-entry register slice with in_ready = !out_valid or out_ready.

Reset
REQ-027 clr=1 at a rising edge SHALL set all valid bits 0, all data registers 0, q=0, out_valid=0, occupancy=0.
REQ-028 clr SHALL take priority over flush, in transfer and advance; clr asserted mid-stream SHALL discard all in-flight words.
REQ-029 First acceptance after clr deasserts SHALL be possible on the first edge with clr=0.

Structure
REQ-030 Package dreg_pipe_pkg SHALL hold DEFAULT_WIDTH=8 and DEFAULT_DEPTH=4 constants; no other typedefs required.
REQ-031 One sub-module dreg_stage (one valid bit + WIDTH data register, load/advance/clear inputs) SHALL be instantiated DEPTH times via generate.
REQ-032 Advance chain and occupancy counter SHALL reside in dreg_pipe, not in dreg_stage.

Verification
REQ-033 clr=1 two cycles with d=8'hFF, in_valid=1 -> q=0, out_valid=0, occupancy=0, in_ready=0 throughout.
REQ-034 WIDTH=8, DEPTH=4, single word 8'hA5 accepted at cycle 0, out_ready=1 -> out_valid=1, q=8'hA5 at cycle 4 only.
REQ-035 Stream 8'h01..8'h10 back-to-back, out_ready=1 -> q sequence 8'h01..8'h10 on consecutive cycles, no gaps.
REQ-036 out_ready=0, push 8'h11..8'h14 -> occupancy reaches 4, in_ready=0; push 8'h15 refused; out_ready=1 with in_valid=1 -> q=8'h11 while 8'h15 accepted, occupancy stays 4.
REQ-037 Occupancy 3, flush=1 with in_valid=1, d=8'h77 -> next cycle occupancy=0, out_valid=0; 8'h77 never appears on q.
REQ-038 DEPTH=1 instance: alternate out_ready 1/0 under continuous in_valid -> no word lost or duplicated, order preserved.
